// File: rtl/tl45_pkg.sv
// tl45_pkg: shared divider width and FSM state encoding
package tl45_pkg;
  localparam int DIV_BW = 32;
  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_FIXUP} div_state_t;
endpackage

// File: rtl/tl45_divider.sv
// tl45_divider: multi-cycle radix-2 restoring signed/unsigned divider with divide-by-zero flag
module tl45_divider
  import tl45_pkg::*;
#(
  parameter int BW = DIV_BW
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_wr,
  input  logic          i_signed,
  input  logic [BW-1:0] i_numerator,
  input  logic [BW-1:0] i_denominator,
  output logic          o_busy,
  output logic          o_valid,
  output logic          o_err,
  output logic [BW-1:0] o_quotient
);
  localparam int CW = $clog2(BW);
  div_state_t state;
  logic [CW-1:0] count;
  logic [BW:0] rem;
  logic [BW-1:0] dvd, den;
  logic neg;
  // dvd shifts out dividend bits at the top and collects quotient bits at the bottom
  wire [BW:0] shifted = {rem[BW-1:0], dvd[BW-1]};
  wire [BW:0] diff = shifted - {1'b0, den};
  wire ge = shifted >= {1'b0, den};
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= DIV_IDLE;
      count <= '0;
      rem <= '0;
      dvd <= '0;
      den <= '0;
      neg <= 1'b0;
      o_busy <= 1'b0;
      o_valid <= 1'b0;
      o_err <= 1'b0;
      o_quotient <= '0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        DIV_IDLE: if (i_wr) begin
          if (i_denominator == '0) begin
            o_valid <= 1'b1;
            o_err <= 1'b1;
            o_quotient <= '0;
          end else begin
            dvd <= (i_signed && i_numerator[BW-1]) ? -i_numerator : i_numerator;
            den <= (i_signed && i_denominator[BW-1]) ? -i_denominator : i_denominator;
            neg <= i_signed & (i_numerator[BW-1] ^ i_denominator[BW-1]);
            count <= CW'(BW - 1);
            rem <= '0;
            o_busy <= 1'b1;
            state <= DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          rem <= ge ? diff : shifted;
          dvd <= {dvd[BW-2:0], ge};
          count <= count - 1'b1;
          state <= (count == '0) ? DIV_FIXUP : DIV_BUSY;
        end
        DIV_FIXUP: begin
          o_quotient <= neg ? -dvd : dvd;
          o_valid <= 1'b1;
          o_err <= 1'b0;
          o_busy <= 1'b0;
          state <= DIV_IDLE;
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end
endmodule
